// File: rtl/vdp_cpu_port.sv
// vdp_cpu_port: VDP CPU I/O port with register file, VRAM address and status.
// Optional macro: VDP_EXT_ADDR_EN widens VRAM address to 17 bits via R14[2:0].
//
// Ports:
//   clk, rst_n           clock, async active-low reset
//   io_wr, io_rd, port   CPU strobes; port 0 = data, 1 = control/status
//   din, dout            CPU write data / read data (buffer or S#0)
//   vram_addr/req/we     VRAM request, held until vram_ack
//   vram_wdata/rdata     VRAM write data / read data (sampled on ack)
//   vram_ack             single-cycle completion of the current request
//   vblank               start-of-frame pulse, sets F
//   regs                 flattened register file, reg n at [8n+7:8n]
//   busy, int_n          state != IDLE; active-low interrupt !(F & R1[5])
module vdp_cpu_port #(
  parameter int         NUM_REGS = 8,
  parameter logic [7:0] INIT_R1  = 8'h00,
`ifdef VDP_EXT_ADDR_EN
  localparam int        AW       = 17
`else
  localparam int        AW       = 14
`endif
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  io_wr,
  input  logic                  io_rd,
  input  logic                  port,
  input  logic [7:0]            din,
  output logic [7:0]            dout,
  output logic [AW-1:0]         vram_addr,
  output logic                  vram_req,
  output logic                  vram_we,
  output logic [7:0]            vram_wdata,
  input  logic [7:0]            vram_rdata,
  input  logic                  vram_ack,
  input  logic                  vblank,
  output logic [8*NUM_REGS-1:0] regs,
  output logic                  busy,
  output logic                  int_n
);

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] pend_addr_q, pend_addr_d;
  logic [AW-1:0] inc, new_addr;
  logic [7:0]    buf_q, buf_d;
  logic [7:0]    wdata_q, wdata_d;
  logic [7:0]    first_q, first_d;
  logic          latch_q, latch_d;
  logic          f_q, f_d;
  logic          ovr_q, ovr_d;
  logic          pend_q, pend_d;
  logic          pend_rd_q, pend_rd_d;
  logic [7:0]    reg_q [NUM_REGS];
  logic [7:0]    reg_d [NUM_REGS];
  logic          busy_w;

  assign busy_w = (state_q != IDLE);
  assign inc    = addr_q + AW'(1);

`ifdef VDP_EXT_ADDR_EN
  // R14[2:0] provides the upper address bits (needs NUM_REGS >= 15)
  assign new_addr = {reg_q[14][2:0], din[5:0], first_q};
`else
  assign new_addr = {din[5:0], first_q};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      pend_addr_q <= '0;
      buf_q       <= '0;
      wdata_q     <= '0;
      first_q     <= '0;
      latch_q     <= 1'b0;
      f_q         <= 1'b0;
      ovr_q       <= 1'b0;
      pend_q      <= 1'b0;
      pend_rd_q   <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++)
        reg_q[i] <= (i == 1) ? INIT_R1 : 8'h00;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      pend_addr_q <= pend_addr_d;
      buf_q       <= buf_d;
      wdata_q     <= wdata_d;
      first_q     <= first_d;
      latch_q     <= latch_d;
      f_q         <= f_d;
      ovr_q       <= ovr_d;
      pend_q      <= pend_d;
      pend_rd_q   <= pend_rd_d;
      reg_q       <= reg_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    pend_addr_d = pend_addr_q;
    buf_d       = buf_q;
    wdata_d     = wdata_q;
    first_d     = first_q;
    latch_d     = latch_q;
    f_d         = f_q;
    ovr_d       = ovr_q;
    pend_d      = pend_q;
    pend_rd_d   = pend_rd_q;
    reg_d       = reg_q;

    // VRAM completion; a pending address set takes over once done
    if (vram_ack) begin
      unique case (1'b1)
        (state_q == RD): begin
          buf_d   = vram_rdata;
          addr_d  = inc;
          state_d = IDLE;
        end
        (state_q == WR): begin
          addr_d  = inc;
          state_d = IDLE;
        end
        default: ;
      endcase
`ifdef VDP_EXT_ADDR_EN
      if (busy_w && inc[13:0] == 14'h0)
        reg_d[14][2:0] = inc[16:14];
`endif
      if (busy_w && pend_q) begin
        addr_d  = pend_addr_q;
        state_d = pend_rd_q ? RD : IDLE;
        pend_d  = 1'b0;
      end
    end

    if (io_wr) begin
      if (port) begin
        if (!latch_q) begin
          first_d = din;
          latch_d = 1'b1;
        end else begin
          latch_d = 1'b0;
          if (din[7]) begin
            for (int i = 0; i < NUM_REGS; i++)
              if (din[5:0] == 6'(i))
                reg_d[i] = first_q;
          end else if (busy_w && !vram_ack) begin
            // defer until the current access completes
            pend_d      = 1'b1;
            pend_addr_d = new_addr;
            pend_rd_d   = !din[6];
          end else begin
            pend_d  = 1'b0;
            addr_d  = new_addr;
            state_d = din[6] ? IDLE : RD;
          end
        end
      end else begin
        latch_d = 1'b0;
        if (busy_w) begin
          ovr_d = 1'b1;
        end else begin
          wdata_d = din;
          state_d = WR;
        end
      end
    end else if (io_rd) begin
      latch_d = 1'b0;
      if (port) begin
        f_d   = 1'b0;
        ovr_d = 1'b0;
      end else if (busy_w) begin
        ovr_d = 1'b1;
      end else begin
        state_d = RD;
      end
    end

    // vblank wins over a same-cycle status read
    if (vblank)
      f_d = 1'b1;
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs
    assign regs[8*g +: 8] = reg_q[g];
  end

  assign dout       = port ? {f_q, ovr_q, 6'b0} : buf_q;
  assign vram_addr  = addr_q;
  assign vram_req   = busy_w;
  assign vram_we    = (state_q == WR);
  assign vram_wdata = wdata_q;
  assign busy       = busy_w;
  assign int_n      = !(f_q && reg_q[1][5]);

endmodule

// File: tb/tb_vdp_cpu_port.sv
// tb_vdp_cpu_port: table-driven register checks plus a VRAM request
// scoreboard for the vdp_cpu_port multi-cycle sequences.
`timescale 1ns/1ps
module tb_vdp_cpu_port;
`ifdef VDP_EXT_ADDR_EN
  localparam int AW = 17;
  localparam int NR = 16;
`else
  localparam int AW = 14;
  localparam int NR = 8;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            io_wr = 1'b0;
  logic            io_rd = 1'b0;
  logic            port = 1'b0;
  logic [7:0]      din = 8'h00;
  logic [7:0]      dout;
  logic [AW-1:0]   vram_addr;
  logic            vram_req;
  logic            vram_we;
  logic [7:0]      vram_wdata;
  logic [7:0]      vram_rdata = 8'h00;
  logic            vram_ack = 1'b0;
  logic            vblank = 1'b0;
  logic [8*NR-1:0] regs;
  logic            busy;
  logic            int_n;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } req_t;
  req_t q[$];

  typedef struct {
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [63:0] exp_regs;
  } vec_t;

  always #5 clk = ~clk;

  vdp_cpu_port #(
    .NUM_REGS(NR),
    .INIT_R1 (8'h00)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .io_wr     (io_wr),
    .io_rd     (io_rd),
    .port      (port),
    .din       (din),
    .dout      (dout),
    .vram_addr (vram_addr),
    .vram_req  (vram_req),
    .vram_we   (vram_we),
    .vram_wdata(vram_wdata),
    .vram_rdata(vram_rdata),
    .vram_ack  (vram_ack),
    .vblank    (vblank),
    .regs      (regs),
    .busy      (busy),
    .int_n     (int_n)
  );

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void push(input logic we, input int a,
                               input logic [7:0] d);
    req_t e;
    e.we   = we;
    e.addr = AW'(a);
    e.data = d;
    q.push_back(e);
  endfunction

  task automatic strobe(input logic w, input logic p, input logic [7:0] d);
    @(negedge clk);
    io_wr = w;
    io_rd = !w;
    port  = p;
    din   = d;
    @(negedge clk);
    io_wr = 1'b0;
    io_rd = 1'b0;
  endtask

  task automatic ctrl(input logic [7:0] b0, input logic [7:0] b1);
    strobe(1'b1, 1'b1, b0);
    strobe(1'b1, 1'b1, b1);
  endtask

  task automatic read(input logic p, output logic [7:0] v);
    @(negedge clk);
    io_rd = 1'b1;
    port  = p;
    #1 v = dout;
    @(negedge clk);
    io_rd = 1'b0;
  endtask

  task automatic serve(input logic [7:0] rd);
    req_t e;
    int   n = 0;
    while (!vram_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!vram_req) begin
      checks++;
      errors++;
      $display("FAIL req_timeout: got no vram_req required one");
      return;
    end
    if (q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_req: got addr %h required none", vram_addr);
    end else begin
      e = q.pop_front();
      chk("req_addr", 64'(vram_addr), 64'(e.addr));
      chk("req_we", 64'(vram_we), 64'(e.we));
      if (e.we)
        chk("req_wdata", 64'(vram_wdata), 64'(e.data));
    end
    vram_ack   = 1'b1;
    vram_rdata = rd;
    @(negedge clk);
    vram_ack = 1'b0;
  endtask

  initial begin
    vec_t       tbl[5];
    logic [7:0] v;

    tbl[0] = '{8'hF0, 8'h87, 64'hF000_0000_0000_0000};
    tbl[1] = '{8'h11, 8'hBF, 64'hF000_0000_0000_0000};
    tbl[2] = '{8'h20, 8'h81, 64'hF000_0000_0000_2000};
    tbl[3] = '{8'h55, 8'h88, 64'hF000_0000_0000_2000};
    tbl[4] = '{8'h3C, 8'h82, 64'hF000_0000_003C_2000};

    repeat (2) @(negedge clk);
    chk("rst_req", 64'(vram_req), 64'd0);
    chk("rst_int_n", 64'(int_n), 64'd1);
    chk("rst_addr", 64'(vram_addr), 64'd0);
    chk("rst_regs", regs[63:0], 64'h0);
    chk("rst_buf", 64'(dout), 64'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      ctrl(tbl[i].b0, tbl[i].b1);
      chk($sformatf("regs_vec%0d", i), regs[63:0], tbl[i].exp_regs);
    end
    chk("tbl_busy", 64'(busy), 64'd0);

    ctrl(8'h34, 8'h43);
    chk("set_addr", 64'(vram_addr), 64'h0334);
    chk("set_noreq", 64'(vram_req), 64'd0);
    push(1'b1, 'h0334, 8'hAA);
    strobe(1'b1, 1'b0, 8'hAA);
    serve(8'h00);
    chk("wr_incr", 64'(vram_addr), 64'h0335);

    @(negedge clk);
    vram_ack = 1'b1;
    @(negedge clk);
    vram_ack = 1'b0;
    chk("idle_ack_addr", 64'(vram_addr), 64'h0335);
    chk("idle_ack_busy", 64'(busy), 64'd0);

    push(1'b0, 'h0000, 8'h00);
    ctrl(8'h00, 8'h00);
    serve(8'h5A);
    push(1'b0, 'h0001, 8'h00);
    read(1'b0, v);
    chk("rd_buf", 64'(v), 64'h5A);
    serve(8'h00);
    chk("rd_incr", 64'(vram_addr), 64'h0002);

    chk("pre_vbl_int", 64'(int_n), 64'd1);
    @(negedge clk);
    vblank = 1'b1;
    @(negedge clk);
    vblank = 1'b0;
    chk("vbl_int", 64'(int_n), 64'd0);
    read(1'b1, v);
    chk("stat1", 64'(v), 64'h80);
    chk("stat_int_clr", 64'(int_n), 64'd1);
    read(1'b1, v);
    chk("stat2", 64'(v), 64'h00);

    ctrl(8'h00, 8'h40);
    push(1'b1, 'h0000, 8'h11);
    strobe(1'b1, 1'b0, 8'h11);
    strobe(1'b1, 1'b0, 8'h22);
    read(1'b1, v);
    chk("ovr_stat", 64'(v), 64'h40);
    serve(8'h00);
    chk("ovr_addr", 64'(vram_addr), 64'h0001);
    read(1'b1, v);
    chk("ovr_clr", 64'(v), 64'h00);

    push(1'b1, 'h0001, 8'h33);
    strobe(1'b1, 1'b0, 8'h33);
    ctrl(8'h10, 8'h00);
    ctrl(8'h20, 8'h00);
    push(1'b0, 'h0020, 8'h00);
    serve(8'h00);
    serve(8'h9C);
    chk("pend_addr", 64'(vram_addr), 64'h0021);
    push(1'b0, 'h0021, 8'h00);
    read(1'b0, v);
    chk("pend_buf", 64'(v), 64'h9C);
    serve(8'h00);

`ifdef VDP_EXT_ADDR_EN
    ctrl(8'h01, 8'h8E);
    ctrl(8'hFF, 8'h7F);
    push(1'b1, 'h07FFF, 8'h01);
    strobe(1'b1, 1'b0, 8'h01);
    serve(8'h00);
    chk("wrap_addr", 64'(vram_addr), 64'h08000);
    chk("wrap_r14", 64'(regs[8*14 +: 8]), 64'h02);
`else
    ctrl(8'hFF, 8'h7F);
    chk("pre_wrap", 64'(vram_addr), 64'h3FFF);
    push(1'b1, 'h3FFF, 8'h01);
    strobe(1'b1, 1'b0, 8'h01);
    serve(8'h00);
    chk("wrap_addr", 64'(vram_addr), 64'h0000);
`endif

    ctrl(8'h00, 8'h50);
    strobe(1'b1, 1'b0, 8'h05);
    chk("mid_wr_req", 64'(vram_req), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_drop_req", 64'(vram_req), 64'd0);
    chk("rst_regs2", regs[63:0], 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    vram_ack = 1'b1;
    @(negedge clk);
    vram_ack = 1'b0;
    chk("rst_ack_busy", 64'(busy), 64'd0);
    chk("rst_ack_addr", 64'(vram_addr), 64'h0);

    @(negedge clk);
    vblank = 1'b1;
    io_rd  = 1'b1;
    port   = 1'b1;
    #1 v = dout;
    @(negedge clk);
    vblank = 1'b0;
    io_rd  = 1'b0;
    chk("vbl_rd_same", 64'(v), 64'h00);
    read(1'b1, v);
    chk("vbl_rd_f_set", 64'(v), 64'h80);
    read(1'b1, v);
    chk("vbl_rd_f_clr", 64'(v), 64'h00);

    chk("queue_empty", 64'(q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1);
  end

endmodule
